// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, frame constants, parity helper.
// Used by both the transmit and receive paths.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int CLKS_PER_BIT_DEFAULT = 5208;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  function automatic logic even_parity(
    input logic [DATA_BITS-1:0] d
  );
    return ^d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the
// terminal count. Held at zero while clear is asserted.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == TERM);

  always_ff @(posedge clk) begin
    if (rst || clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits LSB-first, even parity,
// STOP_BITS stop bits. tx is driven straight from a flop.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  uart_state_e state, state_n;
  logic [7:0]  sh, sh_n;
  logic        par, par_n;
  logic [2:0]  bit_idx, bit_idx_n;
  logic        stop_cnt, stop_cnt_n;
  logic        tx_q, tx_n;
  logic        done_q, done_n;
  logic        tick;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clear(state == IDLE),
    .tick (tick)
  );

  assign tx_ready = (state == IDLE);
  assign tx_done  = done_q;
  assign tx       = tx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sh       <= '0;
      par      <= 1'b0;
      bit_idx  <= '0;
      stop_cnt <= 1'b0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state    <= state_n;
      sh       <= sh_n;
      par      <= par_n;
      bit_idx  <= bit_idx_n;
      stop_cnt <= stop_cnt_n;
      tx_q     <= tx_n;
      done_q   <= done_n;
    end
  end

  // tx_n is the line level for the bit that begins at the next edge
  always_comb begin
    state_n    = state;
    sh_n       = sh;
    par_n      = par;
    bit_idx_n  = bit_idx;
    stop_cnt_n = stop_cnt;
    tx_n       = tx_q;
    done_n     = 1'b0;
    unique case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (tx_start) begin
          state_n   = START;
          sh_n      = tx_data;
          par_n     = even_parity(tx_data);
          bit_idx_n = '0;
          tx_n      = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          state_n = DATA;
          tx_n    = sh[0];
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_idx == LAST_BIT) begin
            state_n   = PARITY;
            bit_idx_n = '0;
            tx_n      = par;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            sh_n      = sh >> 1;
            tx_n      = sh[1];
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_n    = STOP;
          stop_cnt_n = 1'b0;
          tx_n       = 1'b1;
        end
      end
      STOP: begin
        tx_n = 1'b1;
        if (tick) begin
          if (stop_cnt == LAST_STOP) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            stop_cnt_n = stop_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

endmodule
